// File: rtl/bcd_pkg.sv
// bcd_pkg: shared constants and state encoding for the digit-serial BCD adder/subtractor
package bcd_pkg;
   localparam logic [3:0] BCD_CORR = 4'd6;
   localparam logic [3:0] BCD_MAX  = 4'd9;
   typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;
endpackage

// File: rtl/bcd_digit_add.sv
// bcd_digit_add: one BCD digit add with exact over-9 detection and +6 correction
module bcd_digit_add
   import bcd_pkg::*;
(
   input  logic [3:0] x,
   input  logic [3:0] y,
   input  logic       ci,
   output logic [3:0] d,
   output logic       co
);
   logic [4:0] t;
   always_comb begin
      t  = {1'b0, x} + {1'b0, y} + {4'd0, ci};
      co = t > {1'b0, BCD_MAX};
      d  = co ? t[3:0] + BCD_CORR : t[3:0];
   end
endmodule

// File: rtl/bcd_serial_addsub.sv
// bcd_serial_addsub: DIGITS-wide BCD add/subtract, one digit per clock, LSD first
module bcd_serial_addsub
   import bcd_pkg::*;
#(
   parameter int DIGITS = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic                mode,
   input  logic [4*DIGITS-1:0] a,
   input  logic [4*DIGITS-1:0] b,
   input  logic                cin,
   output logic [4*DIGITS-1:0] s,
   output logic                cout,
   output logic                neg,
   output logic                err,
   output logic                busy,
   output logic                done
);
   localparam int W  = 4 * DIGITS;
   localparam int IW = DIGITS > 1 ? $clog2(DIGITS) : 1;
   localparam logic [IW-1:0] LAST = IW'(DIGITS - 1);
   state_t state_q, state_d;
   logic [W-1:0] a_q, b_q, s_q;
   logic [IW-1:0] i_q;
   logic mode_q, carry_q, err_q, cout_q, neg_q, done_q;
   logic [3:0] a_dig, b_dig, bd, dig;
   logic co;
   always_ff @(posedge clk)
      state_q <= rst ? IDLE : state_d;
   always_comb
      state_d = state_q == IDLE ? (start ? RUN : IDLE) :
                state_q == RUN  ? (i_q == LAST ? DONE : RUN) : IDLE;
   always_comb begin
      busy = state_q != IDLE;
      s    = s_q;
      cout = cout_q;
      neg  = neg_q;
      err  = err_q;
      done = done_q;
   end
   // subtract as a + nines'-complement(b) + 1
   always_comb begin
      a_dig = a_q[4*i_q +: 4];
      b_dig = b_q[4*i_q +: 4];
      bd    = mode_q ? BCD_MAX - b_dig : b_dig;
   end
   bcd_digit_add u_dig (.x(a_dig), .y(bd), .ci(carry_q), .d(dig), .co(co));
   always_ff @(posedge clk) begin
      if (rst) begin
         a_q <= '0; b_q <= '0; s_q <= '0; i_q <= '0;
         mode_q <= 1'b0; carry_q <= 1'b0; err_q <= 1'b0;
         cout_q <= 1'b0; neg_q <= 1'b0; done_q <= 1'b0;
      end else begin
         done_q <= state_q == DONE;
         if (state_q == IDLE && start) begin
            a_q <= a; b_q <= b; mode_q <= mode;
            carry_q <= mode | cin;
            err_q <= 1'b0; s_q <= '0; i_q <= '0;
         end
         if (state_q == RUN) begin
            s_q[4*i_q +: 4] <= dig;
            carry_q <= co;
            err_q <= err_q | (a_dig > BCD_MAX) | (b_dig > BCD_MAX);
            i_q <= i_q == LAST ? '0 : i_q + 1'b1;
         end
         if (state_q == DONE) begin
            cout_q <= carry_q;
            neg_q  <= mode_q & ~carry_q;
         end
      end
   end
endmodule
